// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, FIFO depth and saturation limits for the IIR output formatter
package iir_pkg;
    localparam int OUT_W      = 16;
    localparam int IN_W       = 40;
    localparam int IN_FRAC    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SAT_MAX    = 32767;
    localparam int SAT_MIN    = -32768;
    localparam logic [OUT_W-1:0] SAT_HI = 16'h7FFF;
    localparam logic [OUT_W-1:0] SAT_LO = 16'h8000;
    typedef logic [OUT_W-1:0] word_t;
endpackage

// File: rtl/iir5_out_fmt_if.sv
// iir5_out_fmt_if: sample input and ready/valid output stream of the formatter
interface iir5_out_fmt_if;
    import iir_pkg::*;
    logic                   in_valid;
    logic signed [IN_W-1:0] y_in;
    logic                   out_valid;
    logic                   out_ready;
    word_t                  out_data;
    modport master(output in_valid, y_in, out_ready, input out_valid, out_data);
    modport slave(input in_valid, y_in, out_ready, output out_valid, out_data);
endinterface

// File: rtl/iir_fifo4.sv
// iir_fifo4: synchronous first-word-fall-through FIFO; push while full succeeds only with a pop
module iir_fifo4
    import iir_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  word_t      wdata,
    input  logic       rd,
    output word_t      rdata,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    word_t mem_q [FIFO_DEPTH];
    word_t mem_d [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [2:0] cnt_q, cnt_d;
    logic push, pop;
    always_comb begin
        empty = cnt_q == 3'd0;
        full = cnt_q == 3'(FIFO_DEPTH);
        pop = rd && !empty;
        push = wr && (!full || pop);
        mem_d = mem_q;
        if (push) mem_d[wp_q] = wdata;
        wp_d = wp_q + PW'(push);
        rp_d = rp_q + PW'(pop);
        cnt_d = cnt_q + 3'(push) - 3'(pop);
        count = cnt_q;
        rdata = empty ? '0 : mem_q[rp_q];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/iir5_out_fmt.sv
// iir5_out_fmt: decimate-by-sum, round and narrow IIR output into a 4-deep ready/valid FIFO
// Define IIR_OUT_SAT_EN to clamp out-of-range results and report them on sat_flag.
module iir5_out_fmt
    import iir_pkg::*;
#(
    parameter int DEC_LOG2 = 2,
    parameter int RSHIFT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    iir5_out_fmt_if.slave        bus,
    output logic [2:0]           fill,
    output logic                 sat_flag,
    output logic                 drop_flag,
    input  logic                 clr_flags
);
    localparam int AW = IN_W + DEC_LOG2;
    localparam int SW = AW + 1;
    localparam int S  = DEC_LOG2 + RSHIFT;
    localparam int CW = DEC_LOG2 > 0 ? DEC_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << DEC_LOG2) - 1);
    localparam logic signed [SW-1:0] RND = SW'((64'd1 << S) >> 1);
`ifdef IIR_OUT_SAT_EN
    localparam int RW = SW;
`else
    localparam int RW = OUT_W;
`endif
    logic signed [AW-1:0] acc_q, acc_d, sum_q, sum_d, acc_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr_q, wr_d, sat_q, sat_d, drop_q, drop_d, last, full, empty;
    logic signed [RW-1:0] res;
    word_t word;
    always_comb begin
        acc_nxt = acc_q + AW'(bus.y_in);
        last = bus.in_valid && cnt_q == CNT_LAST;
        acc_d = last ? '0 : bus.in_valid ? acc_nxt : acc_q;
        cnt_d = last ? '0 : bus.in_valid ? cnt_q + CW'(1) : cnt_q;
        sum_d = last ? acc_nxt : sum_q;
        wr_d = last;
        // rounding constant is zero when S is zero, so that case passes straight through
        res = RW'((SW'(sum_q) + RND) >>> S);
        drop_d = (drop_q && !clr_flags) || (wr_q && full && !bus.out_ready);
`ifdef IIR_OUT_SAT_EN
        word = res > SW'(SAT_MAX) ? SAT_HI : res < SW'(SAT_MIN) ? SAT_LO : res[OUT_W-1:0];
        sat_d = (sat_q && !clr_flags) || (wr_q && (res > SW'(SAT_MAX) || res < SW'(SAT_MIN)));
`else
        word = res[OUT_W-1:0];
        sat_d = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            wr_q <= 1'b0;
            sat_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            wr_q <= wr_d;
            sat_q <= sat_d;
            drop_q <= drop_d;
        end
    end
    iir_fifo4 u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_q),
        .wdata (word),
        .rd    (bus.out_ready),
        .rdata (bus.out_data),
        .full  (full),
        .empty (empty),
        .count (fill)
    );
    assign bus.out_valid = !empty;
    assign sat_flag = sat_q;
    assign drop_flag = drop_q;
endmodule

// File: doc/iir5_out_fmt.md
IIR5_OUT_FMT -- requirements
Module: iir5_out_fmt

Interface
REQ-001 Parameter DEC_LOG2, default 2: decimation factor DEC = 2^DEC_LOG2 (1..4 legal).
REQ-002 Parameter RSHIFT, default 8: extra LSBs discarded after averaging (0..24 legal).
REQ-003 Port clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  y_in carries a new filter output sample this cycle.
REQ-006 Port y_in  input  40  signed filter output, 16 fractional bits (IIR y_out format).
REQ-007 Port out_valid  output  1  out_data holds a valid word.
REQ-008 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 Port out_data  output  16  signed decimated, rounded result.
REQ-010 Port fill  output  3  current FIFO occupancy, 0..4.
REQ-011 Port sat_flag  output  1  sticky: a result exceeded the 16-bit range.
REQ-012 Port drop_flag  output  1  sticky: a result was lost because the FIFO was full.
REQ-013 Port clr_flags  input  1  clears sat_flag and drop_flag.

Function
REQ-014 Accumulator (width 40+DEC_LOG2, signed) SHALL add y_in on each in_valid cycle; sample counter SHALL wrap modulo DEC.
REQ-015 On the DEC-th accepted sample, the accumulator SHALL reload with zero plus nothing; the completed sum (including that sample) SHALL be registered for formatting; no sample is lost across the dump.
REQ-016 Formatting: total shift S = DEC_LOG2+RSHIFT; result = (sum + 2^(S-1)) >>> S (round half up, arithmetic); S = 0 means no rounding.
REQ-017 The formatted word SHALL be written into a 4-entry FIFO one cycle after the sum register loads.
REQ-018 Latency: with the FIFO empty, out_valid SHALL rise in the 2nd cycle after the edge sampling the DEC-th in_valid.
REQ-019 Handshake: a word is consumed on cycles where out_valid and out_ready are both high; out_data SHALL be stable while out_valid is high and out_ready low.
REQ-020 out_valid SHALL equal (fill != 0); out_data SHALL show the oldest entry (first-word fall-through).
REQ-021 Write while full and no pop: word dropped, FIFO unchanged, drop_flag set.
REQ-022 Write while full with simultaneous pop: write accepted, fill stays 4, no drop.
REQ-023 Pop while empty: ignored.
REQ-024 clr_flags in the same cycle as a new sat/drop event: the event wins, flag ends set.

Reset
REQ-025 reset SHALL clear accumulator, sample counter, sum register, pending-write strobe, FIFO pointers, sat_flag and drop_flag; out_valid=0, fill=0, out_data=0 in the cycle after reset.
REQ-026 Reset mid-accumulation SHALL discard partial sums; counting restarts at the first in_valid after reset is released.

Configuration
REQ-027 Macro IIR_OUT_SAT_EN defined: results outside [-32768, 32767] clamp to 0x8000/0x7FFF and set sat_flag.
REQ-028 Macro IIR_OUT_SAT_EN undefined: result truncated to its 16 LSBs (wrap); sat_flag tied 0.

Structure
REQ-029 Shared package iir_pkg SHALL hold OUT_W=16, IN_W=40, IN_FRAC=16, FIFO_DEPTH=4 and the saturation-limit constants.
REQ-030 FIFO SHALL be a separate sub-module iir_fifo4 (synchronous, FWFT, full/empty/count outputs); accumulation and formatting stay in iir5_out_fmt.

Verification (DEC_LOG2=2, RSHIFT=8, out_ready=1 unless stated)
REQ-031 Four in_valid samples y_in=0x0000010000 -> out_data=0x0100, out_valid exactly 2 cycles after the 4th sample edge.
REQ-032 Samples 128,128,128,127 -> 0x0000; samples 128 x4 -> 0x0001 (rounding boundary).
REQ-033 Four samples 0x7FFFFFFFFF -> 0x7FFF, sat_flag=1 (SAT_EN); four samples 0x8000000000 -> 0x8000; without SAT_EN -> wrapped LSBs, sat_flag=0.
REQ-034 out_ready=0, five result groups -> fill=4, first four words retained in order, fifth dropped, drop_flag=1; clr_flags -> flag 0.
REQ-035 Full FIFO, out_ready=1 in the same cycle a result writes -> fill stays 4, drop_flag stays 0.
REQ-036 Three samples, reset pulse, then four samples 0x0000010000 -> single output 0x0100, no earlier output.
